// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier controller sequencing a shared W-bit ALU
// Ports:
//   Clk, Reset          rising-edge clock, synchronous active-high reset
//   start, a, b         request with multiplicand/multiplier, sampled in IDLE
//   busy, done, result  handshake status and product mod 2^W (held until next start)
//   alu_a, alu_b, alu_op  drive the shared ALU inputs
//   alu_out, alu_zero   combinational ALU result and zero flag
module alu_mul_seq #(
  parameter int W   = 8,
  parameter int Ops = 3
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [Ops-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero
);
  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_SHR = Ops'(1);
  localparam logic [Ops-1:0] OP_SHL = Ops'(2);
  typedef enum logic [2:0] {S_IDLE, S_TEST, S_ADD, S_SHL, S_SHR, S_DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, result_q, result_d;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  // The TEST state passes mplier through the ALU so its Zero flag ends the loop.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_ADD;
    case (state_q)
      S_IDLE: if (start) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        state_d  = S_TEST;
      end
      S_TEST: begin
        alu_a   = mplier_q;
        state_d = alu_zero ? S_DONE : (mplier_q[0] ? S_ADD : S_SHL);
      end
      S_ADD: begin
        alu_a   = acc_q;
        alu_b   = mcand_q;
        acc_d   = alu_out;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_a   = mcand_q;
        alu_b   = W'(1);
        alu_op  = OP_SHL;
        mcand_d = alu_out;
        state_d = S_SHR;
      end
      S_SHR: begin
        alu_a    = mplier_q;
        alu_b    = W'(1);
        alu_op   = OP_SHR;
        mplier_d = alu_out;
        state_d  = S_TEST;
      end
      S_DONE: begin
        result_d = acc_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign busy   = state_q != S_IDLE;
  assign done   = state_q == S_DONE;
  assign result = result_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: self-checking bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;
  logic       Clk = 0, Reset = 1, start = 0;
  logic [7:0] a = 0, b = 0, result, alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       busy, done, alu_zero;
  int errors = 0, checks = 0;
  alu_mul_seq #(.W(8), .Ops(3)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );
  always #5 Clk = ~Clk;
  always_comb begin
    alu_out = alu_op == 3'd1 ? alu_a >> alu_b : alu_op == 3'd2 ? alu_a << alu_b : alu_a + alu_b;
    alu_zero = alu_out == 8'd0;
  end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Expected ALU op per busy cycle: per multiplier bit up to the top set bit,
  // a pass-through TEST, an ADD if the bit is set, then SHL and SHR; one final TEST.
  task automatic run_op(input logic [7:0] ra, input logic [7:0] rb, input int pulse_at);
    logic [2:0] q[$];
    logic [7:0] m;
    logic [7:0] exp_res;
    int exp_cycle, got_cycle;
    m = rb;
    while (m != 0) begin
      q.push_back(3'd0);
      if (m[0]) q.push_back(3'd0);
      q.push_back(3'd2);
      q.push_back(3'd1);
      m = m >> 1;
    end
    q.push_back(3'd0);
    exp_cycle = q.size() + 1;
    exp_res = 8'((32'(ra) * 32'(rb)) % 256);
    a = ra; b = rb; start = 1;
    tick();
    start = 0;
    got_cycle = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == pulse_at) begin start = 1; a = 7; b = 7; end
      if (c == pulse_at + 1) start = 0;
      if (done) begin got_cycle = c; break; end
      if (!busy || (c - 1 < q.size() && alu_op !== q[c-1])) begin
        chk("busy_seq", {busy, alu_op}, {1'b1, (c - 1 < q.size()) ? q[c-1] : 3'd0});
      end
      tick();
    end
    chk("done_cycle", got_cycle, exp_cycle);
    chk("busy_in_done", busy, 1'b1);
    start = 0;
    tick();
    chk("done_pulse", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("result", result, exp_res);
    chk("idle_op", alu_op, 3'd0);
  endtask
  initial begin
    Reset = 1; start = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_result", result, 8'd0);
      chk("rst_op", alu_op, 3'd0);
      chk("rst_alu_a", alu_a, 8'd0);
    end
    Reset = 0; start = 0;
    tick();
    run_op(8'd3, 8'd0, -1);
    run_op(8'd3, 8'd5, -1);
    run_op(8'd200, 8'd3, -1);
    run_op(8'd1, 8'hFF, 10);
    run_op(8'd0, 8'h9A, -1);
    a = 3; b = 5; start = 1;
    tick();
    start = 0;
    for (int c = 1; c <= 6; c++) begin
      chk("pre_abort_done", done, 1'b0);
      if (c == 6) Reset = 1;
      tick();
    end
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 8'd0);
    chk("abort_op", alu_op, 3'd0);
    Reset = 0;
    tick();
    chk("abort_no_done", done, 1'b0);
    run_op(8'd4, 8'd2, -1);
    for (int i = 0; i < 20; i++) begin
      tick();
      run_op(8'($urandom), 8'($urandom), -1);
    end
    start = 1;
    a = 9; b = 9;
    tick();
    start = 0;
    chk("b2b_accept", busy, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
